// File: rtl/ladybird_config.sv
// Shared configuration for the ladybird core slice: data width, arbiter FSM
// state encoding and a small index-width helper.
package ladybird_config;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ladybird_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr,
// wrapping, as a one-hot grant plus its index.
module ladybird_rr_pick
    import ladybird_config::*;
#(
    parameter int N = 2,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ladybird_bus_arbiter.sv
// Round-robin arbiter sharing one bus target between N_MST requesters, with one
// transaction in flight and a per-transaction response timeout.
module ladybird_bus_arbiter #(
    parameter int N_MST   = 2,
    parameter int TIMEOUT = 255,
    parameter int XLEN    = ladybird_config::XLEN
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [N_MST-1:0]        m_req,
    output logic [N_MST-1:0]        m_gnt,
    input  logic [N_MST*XLEN-1:0]   m_addr,
    input  logic [N_MST-1:0]        m_we,
    input  logic [N_MST*XLEN/8-1:0] m_wstrb,
    input  logic [N_MST*XLEN-1:0]   m_wdata,
    output logic [N_MST-1:0]        m_rvalid,
    output logic [XLEN-1:0]         m_rdata,
    output logic                    m_err,
    output logic                    s_req,
    input  logic                    s_gnt,
    output logic [XLEN-1:0]         s_addr,
    output logic                    s_we,
    output logic [XLEN/8-1:0]       s_wstrb,
    output logic [XLEN-1:0]         s_wdata,
    input  logic                    s_rvalid,
    input  logic [XLEN-1:0]         s_rdata
);
    import ladybird_config::*;

    localparam int IW = idx_w(N_MST);
    localparam int SW = XLEN / 8;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t       state, state_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    owner;
    logic [TW-1:0]    tcnt;
    logic [N_MST-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             tmo_hit;
    logic             done;

    ladybird_rr_pick #(.N(N_MST)) u_pick (
        .req (m_req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Fires in the cycle in which the counter would reach TIMEOUT.
    assign tmo_hit = (TIMEOUT != 0) && (state != ARB_IDLE) && (tcnt == TW'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        m_gnt     = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_err     = 1'b0;
        s_req     = 1'b0;
        done      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    m_gnt     = pick_gnt;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                s_req = 1'b1;
                if (s_gnt && s_rvalid) begin
                    done            = 1'b1;
                    m_rvalid[owner] = 1'b1;
                    m_rdata         = s_rdata;
                end else if (tmo_hit) begin
                    s_req           = 1'b0;
                    done            = 1'b1;
                    m_rvalid[owner] = 1'b1;
                    m_err           = 1'b1;
                end else if (s_gnt) begin
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (s_rvalid) begin
                    done            = 1'b1;
                    m_rvalid[owner] = 1'b1;
                    m_rdata         = s_rdata;
                end else if (tmo_hit) begin
                    done            = 1'b1;
                    m_rvalid[owner] = 1'b1;
                    m_err           = 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
        if (done) state_nxt = ARB_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            tcnt    <= '0;
            s_addr  <= '0;
            s_we    <= 1'b0;
            s_wstrb <= '0;
            s_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && pick_any) begin
                owner   <= pick_idx;
                tcnt    <= '0;
                s_addr  <= m_addr[pick_idx*XLEN +: XLEN];
                s_we    <= m_we[pick_idx];
                s_wstrb <= m_wstrb[pick_idx*SW +: SW];
                s_wdata <= m_wdata[pick_idx*XLEN +: XLEN];
            end else if (state != ARB_IDLE) begin
                tcnt <= tcnt + 1'b1;
            end
            if (done) rr_ptr <= (owner == IW'(N_MST - 1)) ? '0 : owner + 1'b1;
        end
    end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Directed bench for ladybird_bus_arbiter: two requesters, TIMEOUT=8, target
// responses driven by hand cycle by cycle.
module tb_ladybird_bus_arbiter;

    localparam int N   = 2;
    localparam int XL  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_gnt;
    logic [N*XL-1:0] m_addr = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*XL/8-1:0] m_wstrb = '0;
    logic [N*XL-1:0] m_wdata = '0;
    logic [N-1:0]    m_rvalid;
    logic [XL-1:0]   m_rdata;
    logic            m_err;
    logic            s_req;
    logic            s_gnt = 1'b0;
    logic [XL-1:0]   s_addr;
    logic            s_we;
    logic [XL/8-1:0] s_wstrb;
    logic [XL-1:0]   s_wdata;
    logic            s_rvalid = 1'b0;
    logic [XL-1:0]   s_rdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ladybird_bus_arbiter #(.N_MST(N), .TIMEOUT(TMO), .XLEN(XL)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .m_req    (m_req),
        .m_gnt    (m_gnt),
        .m_addr   (m_addr),
        .m_we     (m_we),
        .m_wstrb  (m_wstrb),
        .m_wdata  (m_wdata),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .m_err    (m_err),
        .s_req    (s_req),
        .s_gnt    (s_gnt),
        .s_addr   (s_addr),
        .s_we     (s_we),
        .s_wstrb  (s_wstrb),
        .s_wdata  (s_wdata),
        .s_rvalid (s_rvalid),
        .s_rdata  (s_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] eg;

        // reset state
        step; step;
        #1;
        check_eq("rst_sreq",   32'(s_req),    0);
        check_eq("rst_saddr",  s_addr,        0);
        check_eq("rst_swe",    32'(s_we),     0);
        check_eq("rst_swstrb", 32'(s_wstrb),  0);
        check_eq("rst_swdata", s_wdata,       0);
        check_eq("rst_mrv",    32'(m_rvalid), 0);
        nrst = 1'b1;

        // both requesters hold m_req, target answers in the first s_req cycle
        step;
        m_req = 2'b11;
        m_addr[0 +: 32]  = 32'h0000_0100;
        m_addr[32 +: 32] = 32'h0000_0200;
        s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_00A5;
        #1;
        for (int k = 0; k < 4; k++) begin
            eg = (k % 2 == 0) ? 32'd1 : 32'd2;
            check_eq("rr_gnt",     32'(m_gnt),    eg);
            check_eq("idle_stray", 32'(m_rvalid), 0);
            step; #1;
            check_eq("rr_sreq",  32'(s_req),    1);
            check_eq("rr_saddr", s_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            check_eq("rr_rv",    32'(m_rvalid), eg);
            check_eq("rr_rdata", m_rdata,       32'h0000_00A5);
            check_eq("rr_nogt",  32'(m_gnt),    0);
            step; #1;
        end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        #1;
        check_eq("idle_none", 32'(m_gnt), 0);

        // single read by requester 1, response two cycles after s_gnt
        step;
        m_req = 2'b10; m_addr[32 +: 32] = 32'h9000_0004; m_we = '0;
        #1;
        check_eq("rd_gnt", 32'(m_gnt), 2);
        step;
        m_req = '0; s_gnt = 1'b1;
        #1;
        check_eq("rd_sreq",  32'(s_req), 1);
        check_eq("rd_saddr", s_addr,     32'h9000_0004);
        check_eq("rd_swe",   32'(s_we),  0);
        check_eq("rd_once",  32'(m_gnt), 0);
        step;
        s_gnt = 1'b0;
        #1;
        check_eq("rd_wait_sreq", 32'(s_req),    0);
        check_eq("rd_wait_rv",   32'(m_rvalid), 0);
        step;
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("rd_rv",    32'(m_rvalid), 2);
        check_eq("rd_rdata", m_rdata,       32'hDEAD_BEEF);
        check_eq("rd_err",   32'(m_err),    0);
        step;
        s_rvalid = 1'b0;
        #1;
        check_eq("rd_idle_rv",    32'(m_rvalid), 0);
        check_eq("rd_idle_rdata", m_rdata,       0);

        // write by requester 0; registered fields held while s_gnt stays low
        step;
        m_req = 2'b01; m_we = 2'b01; m_addr[0 +: 32] = 32'h0000_0040;
        m_wstrb[0 +: 4] = 4'b0011; m_wdata[0 +: 32] = 32'h1234_5678;
        #1;
        check_eq("wr_gnt", 32'(m_gnt), 1);
        step;
        m_req = '0; m_we = '0; m_wstrb = '1; m_wdata = '1;
        #1;
        check_eq("wr_swe",    32'(s_we),    1);
        check_eq("wr_swstrb", 32'(s_wstrb), 32'h3);
        check_eq("wr_swdata", s_wdata,      32'h1234_5678);
        check_eq("wr_sreq",   32'(s_req),   1);
        step;
        s_gnt = 1'b1; s_rvalid = 1'b1;
        #1;
        check_eq("wr_hold_swe",    32'(s_we),     1);
        check_eq("wr_hold_swstrb", 32'(s_wstrb),  32'h3);
        check_eq("wr_hold_swdata", s_wdata,       32'h1234_5678);
        check_eq("wr_rv",          32'(m_rvalid), 1);
        step;
        s_gnt = 1'b0; s_rvalid = 1'b0; m_wstrb = '0; m_wdata = '0;

        // timeout: target never grants; pointer now favours requester 1
        step;
        m_req = 2'b11; s_rdata = 32'h0000_0055; m_wdata[0 +: 32] = 32'hCAFE_F00D;
        #1;
        check_eq("to_gnt", 32'(m_gnt), 2);
        for (int k = 1; k < TMO; k++) begin
            step;
            m_req = 2'b01;
            #1;
            check_eq("to_pend_rv",   32'(m_rvalid), 0);
            check_eq("to_pend_sreq", 32'(s_req),    1);
        end
        step; #1;
        check_eq("to_rv",    32'(m_rvalid), 2);
        check_eq("to_err",   32'(m_err),    1);
        check_eq("to_rdata", m_rdata,       0);
        step; #1;
        check_eq("to_sreq_drop", 32'(s_req),    0);
        check_eq("to_next_gnt",  32'(m_gnt),    1);
        check_eq("to_next_rv",   32'(m_rvalid), 0);

        // reset in the middle of WAIT
        step;
        m_req = '0; s_gnt = 1'b1;
        #1;
        check_eq("mr_sreq", 32'(s_req), 1);
        step;
        s_gnt = 1'b0; nrst = 1'b0;
        #1;
        check_eq("mr_wait_sreq", 32'(s_req), 0);
        step;
        nrst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_0077;
        #1;
        check_eq("mr_sreq0",   32'(s_req),    0);
        check_eq("mr_saddr0",  s_addr,        0);
        check_eq("mr_swdata0", s_wdata,       0);
        check_eq("mr_gnt0",    32'(m_gnt),    0);
        check_eq("mr_late_rv", 32'(m_rvalid), 0);
        check_eq("mr_rdata0",  m_rdata,       0);
        step;
        s_rvalid = 1'b0; m_req = 2'b10;
        #1;
        check_eq("mr_gnt1", 32'(m_gnt),    2);
        check_eq("mr_rv0",  32'(m_rvalid), 0);
        step;
        m_req = '0; s_gnt = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0000_1111;
        #1;
        check_eq("mr_rv1",    32'(m_rvalid), 2);
        check_eq("mr_rdata1", m_rdata,       32'h0000_1111);
        step;
        s_gnt = 1'b0; s_rvalid = 1'b0;
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
